// File: rtl/ilm_pkg.sv
// Shared widths, helper functions and payload type for the nearest-one ILM pipeline.
// Used by both the default build and the ILM_ITER_EN (correction iteration) build.
package ilm_pkg;

  function automatic int k_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int res_width(input int w);
    return w + 2;
  endfunction

  function automatic int acc_width(input int w);
    return 2 * w + 2;
  endfunction

  localparam int ILM_WIDTH = 8;
  localparam int ILM_TAG_W = 4;
  localparam int RES_W     = res_width(ILM_WIDTH);
  localparam int ACC_W     = acc_width(ILM_WIDTH);
  localparam int K_W       = k_width(ILM_WIDTH);

  // Per-operand stage payload for the default configuration.
  typedef struct packed {
    logic                    zero;
    logic [K_W-1:0]          k;
    logic signed [RES_W-1:0] d;
    logic [ILM_TAG_W-1:0]    tag;
  } ilm_op_t;

endpackage

// File: rtl/nod_n.sv
// Combinational nearest-one detector: k = exponent of the nearest power of two
// (ties round up), d = data - 2^k, zero flags a zero operand (k=0, d=-1).
module nod_n
  import ilm_pkg::*;
#(
  parameter  int W  = 8,
  localparam int KW = k_width(W),
  localparam int DW = res_width(W)
) (
  input  logic [W-1:0]         data,
  output logic [KW-1:0]        k,
  output logic signed [DW-1:0] d,
  output logic                 zero
);

  always_comb begin
    int   lead;
    logic up;
    // NOTE: every combinational variable gets a default before the loop so no latch is inferred.
    lead = 0;
    up   = 1'b0;
    // The bit just below the leading one decides whether the next power up is closer.
    for (int i = 1; i < W; i++) begin
      if (data[i]) begin
        lead = i;
        up   = data[i-1];
      end
    end
    k    = KW'(lead + int'(up));
    zero = (data == '0);
    d    = $signed({2'b00, data}) - $signed(DW'(1) << k);
  end

endmodule

// File: rtl/ilm_nod_pipe.sv
// Three-stage pipelined nearest-one ILM multiplier with global-stall valid/ready.
// Define ILM_ITER_EN to add one correction iteration approximating the dx*dy term.
module ilm_nod_pipe
  import ilm_pkg::*;
#(
  parameter int WIDTH = ILM_WIDTH,
  parameter int TAG_W = ILM_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int KW = k_width(WIDTH);
  localparam int DW = res_width(WIDTH);
  localparam int AW = acc_width(WIDTH);

  typedef struct packed {
    logic                 zero;
    logic [KW-1:0]        k;
    logic signed [DW-1:0] d;
  } nod_t;

  logic                 advance;
  logic                 v1, v2, v3;
  logic [WIDTH-1:0]     x1, y1;
  logic [TAG_W-1:0]     tag1, tag2, tag3;
  logic [KW-1:0]        kx_c, ky_c;
  logic signed [DW-1:0] dx_c, dy_c;
  logic                 zx_c, zy_c;
  nod_t                 x2, y2;
  logic [KW:0]          ksum_c, ksum3;
  logic signed [AW-1:0] tx_c, ty_c, tx3, ty3;
  logic                 zero3;
  logic signed [AW-1:0] acc_c;
  logic [2*WIDTH-1:0]   p_c;

  // One stall signal freezes every stage, so ordering is preserved trivially.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~rst;

  nod_n #(.W(WIDTH)) u_nod_x (.data(x1), .k(kx_c), .d(dx_c), .zero(zx_c));
  nod_n #(.W(WIDTH)) u_nod_y (.data(y1), .k(ky_c), .d(dy_c), .zero(zy_c));

  assign ksum_c = {1'b0, x2.k} + {1'b0, y2.k};
  assign tx_c   = AW'($signed(x2.d)) <<< y2.k;
  assign ty_c   = AW'($signed(y2.d)) <<< x2.k;

`ifdef ILM_ITER_EN
  logic [WIDTH-1:0]     mx_c, my_c;
  logic [KW-1:0]        ckx_c, cky_c;
  logic signed [DW-1:0] cdx_c, cdy_c;
  logic                 czx_c, czy_c;
  logic                 cen3, cneg3;
  logic [KW:0]          cksum3;
  logic signed [AW-1:0] ctx3, cty3;
  logic signed [AW-1:0] corr_c;

  // |d| never exceeds 2^(WIDTH-2), so WIDTH bits hold the magnitude exactly.
  assign mx_c = WIDTH'(x2.d[DW-1] ? -$signed(x2.d) : $signed(x2.d));
  assign my_c = WIDTH'(y2.d[DW-1] ? -$signed(y2.d) : $signed(y2.d));

  nod_n #(.W(WIDTH)) u_nod_cx (.data(mx_c), .k(ckx_c), .d(cdx_c), .zero(czx_c));
  nod_n #(.W(WIDTH)) u_nod_cy (.data(my_c), .k(cky_c), .d(cdy_c), .zero(czy_c));
`endif

  always_comb begin
    acc_c = (AW'(1) << ksum3) + tx3 + ty3;
`ifdef ILM_ITER_EN
    corr_c = (AW'(1) << cksum3) + ctx3 + cty3;
    if (cen3) acc_c = cneg3 ? acc_c - corr_c : acc_c + corr_c;
`endif
    if (zero3 || acc_c[AW-1]) p_c = '0;
    else if (acc_c[AW-2])     p_c = '1;
    else                      p_c = acc_c[2*WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      out_p     <= p_c;
      out_tag   <= tag3;
    end
  end

  // NOTE: datapath registers carry no reset; their contents are ignored until the matching valid is set.
  always_ff @(posedge clk) begin
    if (advance) begin
      x1     <= in_x;
      y1     <= in_y;
      tag1   <= in_tag;
      x2     <= '{zero: zx_c, k: kx_c, d: dx_c};
      y2     <= '{zero: zy_c, k: ky_c, d: dy_c};
      tag2   <= tag1;
      zero3  <= x2.zero | y2.zero;
      ksum3  <= ksum_c;
      tx3    <= tx_c;
      ty3    <= ty_c;
      tag3   <= tag2;
`ifdef ILM_ITER_EN
      cen3   <= ~(czx_c | czy_c);
      cneg3  <= x2.d[DW-1] ^ y2.d[DW-1];
      cksum3 <= {1'b0, ckx_c} + {1'b0, cky_c};
      ctx3   <= AW'(cdx_c) <<< cky_c;
      cty3   <= AW'(cdy_c) <<< ckx_c;
`endif
    end
  end

endmodule

// File: tb/tb_ilm_nod_pipe.sv
// Scoreboard bench for ilm_nod_pipe: directed cases, backpressure, reset, random traffic.
module tb_ilm_nod_pipe;

  localparam int W  = 8;
  localparam int TW = 4;
`ifdef ILM_ITER_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_x = '0;
  logic [W-1:0]    in_y = '0;
  logic [TW-1:0]   in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2*W-1:0]  out_p;
  logic [TW-1:0]   out_tag;

  typedef struct {
    longint p;
    int     tag;
    int     acc_cyc;
    bit     lat;
  } exp_t;

  exp_t           q[$];
  exp_t           e;
  int             tests = 0;
  int             fails = 0;
  int             cyc = 0;
  bit             rand_rdy = 1'b0;
  bit             prev_stall = 1'b0;
  logic [2*W-1:0] prev_p;
  logic [TW-1:0]  prev_tag;

  ilm_nod_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Nearest power of two by direct distance search; ties prefer the larger power.
  function automatic void nearest(input longint v, output int k, output longint d);
    longint best, diff;
    k    = 0;
    best = (v > 1) ? v - 1 : 1 - v;
    for (int c = 1; c <= 2 * W; c++) begin
      diff = v - (longint'(1) << c);
      if (diff < 0) diff = -diff;
      if (diff <= best) begin
        best = diff;
        k    = c;
      end
    end
    d = v - (longint'(1) << k);
  endfunction

  function automatic longint model(input longint x, input longint y);
    int     kx, ky, cx, cy;
    longint dx, dy, ex, ey, p, corr;
    nearest(x, kx, dx);
    nearest(y, ky, dy);
    if (x == 0 || y == 0) return 0;
    p = (longint'(1) << (kx + ky)) + dx * (longint'(1) << ky) + dy * (longint'(1) << kx);
    if (ITER && dx != 0 && dy != 0) begin
      nearest(dx < 0 ? -dx : dx, cx, ex);
      nearest(dy < 0 ? -dy : dy, cy, ey);
      corr = (longint'(1) << (cx + cy)) + ex * (longint'(1) << cy) + ey * (longint'(1) << cx);
      p = ((dx < 0) != (dy < 0)) ? p - corr : p + corr;
    end
    if (p < 0) p = 0;
    if (p > (longint'(1) << (2 * W)) - 1) p = (longint'(1) << (2 * W)) - 1;
    return p;
  endfunction

  task automatic send(input int x, input int y, input int t, input bit lat, input longint p_req);
    int waited;
    exp_t n;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = W'(x);
    in_y     = W'(y);
    in_tag   = TW'(t);
    #1;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      n.p       = p_req;
      n.tag     = t;
      n.acc_cyc = cyc + 1;
      n.lat     = lat;
      q.push_back(n);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    #2;
    check("drain_queue_empty", q.size(), 0);
  endtask

  always @(negedge clk) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_out_valid_held", out_valid, 1);
        check("stall_out_p_held", out_p, prev_p);
        check("stall_out_tag_held", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_output: got tag %0d p %0d, required no output", out_tag, out_p);
        end else begin
          e = q.pop_front();
          check("out_p", out_p, e.p);
          check("out_tag", out_tag, e.tag);
          if (e.lat) check("latency", cyc - e.acc_cyc, 3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = out_p;
      prev_tag   = out_tag;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, sel;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values from the nearest-one rules.
    send(3, 5, 1, 1'b1, ITER ? 64'd15 : 64'd16);
    send(0, 77, 2, 1'b1, 0);
    send(77, 0, 3, 1'b1, 0);
    send(255, 255, 4, 1'b1, ITER ? 64'd65025 : 64'd65024);
    send(192, 192, 5, 1'b1, ITER ? 64'd36864 : 64'd32768);
    send(1, 200, 6, 1'b1, 200);
    wait_drain(50);

    // Backpressure: fill the pipe with the consumer stalled.
    @(negedge clk);
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) send(10 + 7 * t, 20 + 3 * t, t, 1'b0, model(10 + 7 * t, 20 + 3 * t));
    repeat (5) begin
      @(negedge clk);
      #1;
      check("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain(20);

    // Reset with two operations in flight: both must vanish.
    send(9, 9, 7, 1'b0, model(9, 9));
    send(11, 13, 8, 1'b0, model(11, 13));
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    #1;
    check("rst_mid_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    repeat (6) begin
      @(negedge clk);
      #1;
      check("rst_no_stale", out_valid, 0);
    end
    send(100, 3, 9, 1'b1, model(100, 3));
    wait_drain(20);

    // Random traffic with random consumer backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      sel = $urandom_range(0, 9);
      x   = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(0, 255);
      sel = $urandom_range(0, 9);
      y   = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(0, 255);
      send(x, y, i % 16, 1'b0, model(x, y));
    end
    @(negedge clk);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    wait_drain(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
